// File: rtl/lz_expand.sv
// lz_expand: sequential leading-zero expander (value = norm >> lz, one bit per clock); input checking built when LZ_CHECK_EN is defined
module lz_expand #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] norm,
    input  logic [CW-1:0]    lz,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CW-1:0] W_C = CW'(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    lz_clamp;
    logic             accept;

    assign accept   = (state == IDLE) && start;
    assign lz_clamp = (lz > W_C) ? W_C : lz;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state: shift until the counter drains, one DONE cycle, then back to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = (cnt == '0) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift/decrement while counter nonzero, publish value on drain
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sreg  <= '0;
            cnt   <= '0;
            value <= '0;
        end else if (accept) begin
            sreg <= norm;
            cnt  <= lz_clamp;
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                sreg <= sreg >> 1;
                cnt  <= cnt - CW'(1);
            end else begin
                value <= sreg;
            end
        end
    end

`ifdef LZ_CHECK_EN
    logic err_in;
    assign err_in = (lz > W_C)
                 || ((lz < W_C) && !norm[WIDTH-1])
                 || ((lz == W_C) && (norm != '0));

    // Inconsistency flag, computed on the captured inputs and held until the next accepted start
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)     err <= 1'b0;
        else if (accept) err <= err_in;
    end
`else
    assign err = 1'b0;
`endif
endmodule
